// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD timing controller: pixel-format encodings,
// colour-bar constants and a small width helper.
package lcd_pkg;

    typedef enum logic [1:0] {
        MODE_RGB565 = 2'd0,
        MODE_RGB888 = 2'd1,
        MODE_GRAY8  = 2'd2,
        MODE_TEST   = 2'd3
    } pix_mode_e;

    localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
    localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
    localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
    localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
    localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
    localparam logic [23:0] BAR_RED     = 24'hFF0000;
    localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
    localparam logic [23:0] BAR_BLACK   = 24'h000000;

    // Bars are numbered left to right across the active width.
    function automatic logic [23:0] bar_color(input logic [2:0] idx);
        logic [23:0] c;
        c = BAR_BLACK;
        case (idx)
            3'd0: c = BAR_WHITE;
            3'd1: c = BAR_YELLOW;
            3'd2: c = BAR_CYAN;
            3'd3: c = BAR_GREEN;
            3'd4: c = BAR_MAGENTA;
            3'd5: c = BAR_RED;
            3'd6: c = BAR_BLUE;
            default: c = BAR_BLACK;
        endcase
        return c;
    endfunction

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lcd_sync_gen.sv
// Horizontal/vertical counters with raw sync, active-area and frame-start
// decode; everything here is "stage 0" of the display pipeline.
module lcd_sync_gen
    import lcd_pkg::*;
#(
    parameter int H_SYNC   = 40,
    parameter int H_BACK   = 2,
    parameter int H_ACTIVE = 480,
    parameter int H_FRONT  = 2,
    parameter int V_SYNC   = 10,
    parameter int V_BACK   = 2,
    parameter int V_ACTIVE = 272,
    parameter int V_FRONT  = 2,
    parameter int H_W      = cnt_width(H_SYNC + H_BACK + H_ACTIVE + H_FRONT)
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_en,
    output logic [H_W-1:0] o_hcnt,
    output logic           o_hsync_raw,
    output logic           o_vsync_raw,
    output logic           o_active,
    output logic           o_frame_start
);

    localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
    localparam int V_W     = cnt_width(V_TOTAL);
    localparam int H_START = H_SYNC + H_BACK;
    localparam int H_END   = H_START + H_ACTIVE;
    localparam int V_START = V_SYNC + V_BACK;
    localparam int V_END   = V_START + V_ACTIVE;

    logic [H_W-1:0] r_hcnt;
    logic [V_W-1:0] r_vcnt;
    logic           w_h_active;
    logic           w_v_active;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else if (i_en) begin
            if (r_hcnt == H_W'(H_TOTAL - 1)) begin
                r_hcnt <= '0;
                if (r_vcnt == V_W'(V_TOTAL - 1)) begin
                    r_vcnt <= '0;
                end else begin
                    r_vcnt <= r_vcnt + 1'b1;
                end
            end else begin
                r_hcnt <= r_hcnt + 1'b1;
            end
        end
    end

    // Compare in 32 bits so an interval end equal to the total cannot alias.
    assign w_h_active    = (32'(r_hcnt) >= H_START) && (32'(r_hcnt) < H_END);
    assign w_v_active    = (32'(r_vcnt) >= V_START) && (32'(r_vcnt) < V_END);
    assign o_active      = w_h_active && w_v_active;
    assign o_hsync_raw   = 32'(r_hcnt) < H_SYNC;
    assign o_vsync_raw   = 32'(r_vcnt) < V_SYNC;
    assign o_frame_start = (r_hcnt == '0) && (r_vcnt == '0);
    assign o_hcnt        = r_hcnt;

endmodule

// File: rtl/lcd_timing_ctrl.sv
// LCD timing controller: frame-buffer read addressing, pixel-format
// conversion and a fixed two-enabled-cycle sync/DE/RGB pipeline.
module lcd_timing_ctrl
    import lcd_pkg::*;
#(
    parameter int H_SYNC   = 40,
    parameter int H_BACK   = 2,
    parameter int H_ACTIVE = 480,
    parameter int H_FRONT  = 2,
    parameter int V_SYNC   = 10,
    parameter int V_BACK   = 2,
    parameter int V_ACTIVE = 272,
    parameter int V_FRONT  = 2,
    parameter int ADDR_W   = 17,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic              iClk,
    input  logic              iRsn,
    input  logic              iEnClk,
    input  logic [1:0]        iPixMode,
    input  logic [ADDR_W-1:0] iBaseAddr,
    input  logic [23:0]       iRamRdData,
    output logic [ADDR_W-1:0] oRamRdAddr,
    output logic              oRamRdEn,
    output logic              oLcdHSync,
    output logic              oLcdVSync,
    output logic              oLcdDe,
    output logic [7:0]        oLcdR,
    output logic [7:0]        oLcdG,
    output logic [7:0]        oLcdB,
    output logic              oFrameStart
);

    localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int H_W     = cnt_width(H_TOTAL);
    localparam int H_START = H_SYNC + H_BACK;

    logic [H_W-1:0]    w_hcnt;
    logic              w_hsync_raw;
    logic              w_vsync_raw;
    logic              w_active;
    logic              w_frame_start;
    logic [2:0]        w_bar;
    logic [23:0]       w_pix;

    pix_mode_e         r_mode;
    logic [ADDR_W-1:0] r_addr;
    logic              r_frame_start;
    logic              r_act_d1;
    logic              r_act_d2;
    logic              r_hs_d1;
    logic              r_hs_d2;
    logic              r_vs_d1;
    logic              r_vs_d2;
    logic [2:0]        r_bar_d1;
    logic [23:0]       r_rgb;

    lcd_sync_gen #(
        .H_SYNC   (H_SYNC),
        .H_BACK   (H_BACK),
        .H_ACTIVE (H_ACTIVE),
        .H_FRONT  (H_FRONT),
        .V_SYNC   (V_SYNC),
        .V_BACK   (V_BACK),
        .V_ACTIVE (V_ACTIVE),
        .V_FRONT  (V_FRONT),
        .H_W      (H_W)
    ) u_sync_gen (
        .i_clk         (iClk),
        .i_rst_n       (iRsn),
        .i_en          (iEnClk),
        .o_hcnt        (w_hcnt),
        .o_hsync_raw   (w_hsync_raw),
        .o_vsync_raw   (w_vsync_raw),
        .o_active      (w_active),
        .o_frame_start (w_frame_start)
    );

    // Bar index = x * 8 / H_ACTIVE; only meaningful while w_active is set.
    assign w_bar = 3'((32'(w_hcnt - H_W'(H_START)) * 8) / H_ACTIVE);

    // Stage-1 formatting: RAM data for the pixel addressed one enabled cycle ago.
    always_comb begin
        w_pix = '0;
        case (r_mode)
            MODE_RGB565: w_pix = {iRamRdData[15:11], iRamRdData[15:13],
                                  iRamRdData[10:5],  iRamRdData[10:9],
                                  iRamRdData[4:0],   iRamRdData[4:2]};
            MODE_RGB888: w_pix = iRamRdData;
            MODE_GRAY8:  w_pix = {3{iRamRdData[7:0]}};
            default:     w_pix = bar_color(r_bar_d1);
        endcase
    end

    always_ff @(posedge iClk or negedge iRsn) begin
        if (!iRsn) begin
            r_mode        <= MODE_RGB565;
            r_addr        <= '0;
            r_frame_start <= 1'b0;
            r_act_d1      <= 1'b0;
            r_act_d2      <= 1'b0;
            r_hs_d1       <= ~SYNC_POL;
            r_hs_d2       <= ~SYNC_POL;
            r_vs_d1       <= ~SYNC_POL;
            r_vs_d2       <= ~SYNC_POL;
            r_bar_d1      <= '0;
            r_rgb         <= '0;
        end else if (iEnClk) begin
            r_frame_start <= w_frame_start;
            // Base and mode are sampled only here so mid-frame changes wait a frame.
            if (w_frame_start) begin
                r_mode <= pix_mode_e'(iPixMode);
                r_addr <= iBaseAddr;
            end else if (w_active) begin
                r_addr <= r_addr + 1'b1;
            end
            r_act_d1 <= w_active;
            r_act_d2 <= r_act_d1;
            r_hs_d1  <= w_hsync_raw ? SYNC_POL : ~SYNC_POL;
            r_hs_d2  <= r_hs_d1;
            r_vs_d1  <= w_vsync_raw ? SYNC_POL : ~SYNC_POL;
            r_vs_d2  <= r_vs_d1;
            r_bar_d1 <= w_bar;
            r_rgb    <= r_act_d1 ? w_pix : 24'h000000;
        end
    end

    assign oRamRdAddr  = r_addr;
    assign oRamRdEn    = w_active && (r_mode != MODE_TEST);
    assign oLcdHSync   = r_hs_d2;
    assign oLcdVSync   = r_vs_d2;
    assign oLcdDe      = r_act_d2;
    assign oLcdR       = r_rgb[23:16];
    assign oLcdG       = r_rgb[15:8];
    assign oLcdB       = r_rgb[7:0];
    assign oFrameStart = r_frame_start;

endmodule
